// File: rtl/dcache_2way_wb.sv
// 2-way set-associative, write-back, write-allocate data cache.
// CPU side: word port with byte selects and a combinational stall.
// Memory side: whole 128-bit lines, one beat per refill or writeback.

// Tag compare for one way of the addressed set.
module dcache_2way_wb_way_cmp #(
    parameter int TAG_W = 20
) (
    input  logic             valid,
    input  logic [TAG_W-1:0] tag_stored,
    input  logic [TAG_W-1:0] tag_req,
    output logic             hit
);
    assign hit = valid && (tag_stored == tag_req);
endmodule

module dcache_2way_wb #(
    parameter int INDEX_W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cpu_rreq_i,
    input  logic [31:0]  cpu_raddr_i,
    input  logic         cpu_wreq_i,
    input  logic [31:0]  cpu_waddr_i,
    input  logic [31:0]  cpu_wdata_i,
    input  logic [3:0]   cpu_sel_i,
    output logic [31:0]  cpu_rdata_o,
    output logic         stallreq_o,
    output logic         mem_rreq_o,
    output logic [31:0]  mem_raddr_o,
    input  logic         mem_rvalid_i,
    input  logic [127:0] mem_rdata_i,
    output logic         mem_wreq_o,
    output logic [31:0]  mem_waddr_o,
    output logic [127:0] mem_wdata_o,
    input  logic         mem_wack_i
);
    localparam int TAG_W = 32 - 4 - INDEX_W;
    localparam int SETS  = 2 ** INDEX_W;
    localparam int WAYS  = 2;

    typedef enum logic [1:0] {IDLE, LOOKUP, WRITEBACK, REFILL} state_t;

    typedef struct packed {
        logic [31:2] addr;
        logic [31:0] data;
        logic [3:0]  sel;
    } wr_req_t;

    state_t state_q, state_d;

    // Captured CPU requests; a write is always serviced before a read.
    wr_req_t     wr_q;
    logic        wr_pend_q;
    logic        rd_pend_q;
    logic [31:2] rd_addr_q;
    logic        victim_q;

    // Line storage (not reset) and per-set metadata (reset).
    logic [TAG_W-1:0]           tag_mem  [WAYS][SETS];
    logic [127:0]               data_mem [WAYS][SETS];
    logic [WAYS-1:0][SETS-1:0]  valid_q;
    logic [WAYS-1:0][SETS-1:0]  dirty_q;
    logic [SETS-1:0]            lru_q;

    // Requests are word aligned, so the byte offset is ignored.
    logic unused_addr_lo;
    assign unused_addr_lo = ^{cpu_raddr_i[1:0], cpu_waddr_i[1:0]};

    // Address of the operation currently being serviced.
    logic [31:2]        cur_addr;
    logic [INDEX_W-1:0] cur_idx;
    logic [TAG_W-1:0]   cur_tag;
    logic [1:0]         cur_word;

    assign cur_addr = wr_pend_q ? wr_q.addr : rd_addr_q;
    assign cur_idx  = cur_addr[4 +: INDEX_W];
    assign cur_tag  = cur_addr[31 -: TAG_W];
    assign cur_word = cur_addr[3:2];

    logic [WAYS-1:0]             way_hit;
    logic [WAYS-1:0]             way_valid;
    logic [WAYS-1:0][TAG_W-1:0]  way_tag;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        assign way_tag[w]   = tag_mem[w][cur_idx];
        assign way_valid[w] = valid_q[w][cur_idx];
        dcache_2way_wb_way_cmp #(.TAG_W(TAG_W)) u_cmp (
            .valid      (way_valid[w]),
            .tag_stored (way_tag[w]),
            .tag_req    (cur_tag),
            .hit        (way_hit[w])
        );
    end

    logic         hit_way;
    logic [127:0] hit_line;
    logic [31:0]  hit_word;
    logic [31:0]  merged_word;
    logic [127:0] merged_line;
    logic         victim_sel;
    logic         victim_dirty;
    logic         lookup_hit;
    logic         lookup_miss;
    logic         refill_done;
    logic         accept;

    assign hit_way  = way_hit[1];
    assign hit_line = data_mem[hit_way][cur_idx];
    assign hit_word = hit_line[32*cur_word +: 32];

    // Invalid way first (way0 preferred), otherwise the LRU way.
    assign victim_sel   = !way_valid[0] ? 1'b0 :
                          !way_valid[1] ? 1'b1 : lru_q[cur_idx];
    assign victim_dirty = way_valid[victim_sel] && dirty_q[victim_sel][cur_idx];

    assign lookup_miss = (state_q == LOOKUP) && !(|way_hit);
    assign refill_done = (state_q == REFILL) && mem_rvalid_i;
    assign accept      = !stallreq_o && (cpu_rreq_i || cpu_wreq_i);

    // Byte-merge the pending write into the hit line.
    always_comb begin
        merged_word = hit_word;
        for (int b = 0; b < 4; b++) begin
            if (wr_q.sel[b]) merged_word[8*b +: 8] = wr_q.data[8*b +: 8];
        end
        merged_line = hit_line;
        merged_line[32*cur_word +: 32] = merged_word;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state, stall and hit decode.
    always_comb begin
        state_d    = state_q;
        stallreq_o = 1'b1;
        lookup_hit = 1'b0;
        case (state_q)
            IDLE: begin
                stallreq_o = 1'b0;
                if (cpu_rreq_i || cpu_wreq_i) state_d = LOOKUP;
            end
            LOOKUP: begin
                if (|way_hit) begin
                    lookup_hit = 1'b1;
                    if (wr_pend_q && rd_pend_q) begin
                        // Write done this cycle, read still queued behind it.
                        state_d = LOOKUP;
                    end else begin
                        stallreq_o = 1'b0;
                        state_d    = (cpu_rreq_i || cpu_wreq_i) ? LOOKUP : IDLE;
                    end
                end else begin
                    state_d = victim_dirty ? WRITEBACK : REFILL;
                end
            end
            WRITEBACK: if (mem_wack_i)   state_d = REFILL;
            REFILL:    if (mem_rvalid_i) state_d = LOOKUP;
            default:   state_d = IDLE;
        endcase
    end

    // Memory requests are pure state decodes so they drop as soon as reset hits.
    assign mem_wreq_o  = (state_q == WRITEBACK);
    assign mem_waddr_o = mem_wreq_o ? {tag_mem[victim_q][cur_idx], cur_idx, 4'b0} : '0;
    assign mem_wdata_o = mem_wreq_o ? data_mem[victim_q][cur_idx] : '0;
    assign mem_rreq_o  = (state_q == REFILL);
    assign mem_raddr_o = mem_rreq_o ? {cur_tag, cur_idx, 4'b0} : '0;

    // Request capture, read data and per-set metadata.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q        <= '0;
            wr_pend_q   <= 1'b0;
            rd_pend_q   <= 1'b0;
            rd_addr_q   <= '0;
            victim_q    <= 1'b0;
            cpu_rdata_o <= '0;
            valid_q     <= '0;
            dirty_q     <= '0;
            lru_q       <= '0;
        end else begin
            if (lookup_hit) begin
                lru_q[cur_idx] <= ~hit_way;
                if (wr_pend_q) begin
                    wr_pend_q                 <= 1'b0;
                    dirty_q[hit_way][cur_idx] <= 1'b1;
                end else begin
                    rd_pend_q   <= 1'b0;
                    cpu_rdata_o <= hit_word;
                end
            end
            if (lookup_miss) victim_q <= victim_sel;
            if (refill_done) begin
                valid_q[victim_q][cur_idx] <= 1'b1;
                dirty_q[victim_q][cur_idx] <= 1'b0;
                lru_q[cur_idx]             <= ~victim_q;
            end
            // Accept only happens when nothing else is left pending.
            if (accept) begin
                wr_pend_q <= cpu_wreq_i;
                rd_pend_q <= cpu_rreq_i;
                wr_q      <= '{addr: cpu_waddr_i[31:2], data: cpu_wdata_i, sel: cpu_sel_i};
                rd_addr_q <= cpu_raddr_i[31:2];
            end
        end
    end

    // Line storage: write-hit merge and refill install.
    always_ff @(posedge clk) begin
        if (lookup_hit && wr_pend_q) data_mem[hit_way][cur_idx] <= merged_line;
        if (refill_done) begin
            data_mem[victim_q][cur_idx] <= mem_rdata_i;
            tag_mem[victim_q][cur_idx]  <= cur_tag;
        end
    end

endmodule

// File: tb/tb_dcache_2way_wb.sv
// Self-checking bench for dcache_2way_wb: directed scenarios plus random
// traffic against a transaction-level cache/memory model.
module tb_dcache_2way_wb;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cpu_rreq_i, cpu_wreq_i;
    logic [31:0]  cpu_raddr_i, cpu_waddr_i, cpu_wdata_i;
    logic [3:0]   cpu_sel_i;
    logic [31:0]  cpu_rdata_o;
    logic         stallreq_o;
    logic         mem_rreq_o, mem_rvalid_i, mem_wreq_o, mem_wack_i;
    logic [31:0]  mem_raddr_o, mem_waddr_o;
    logic [127:0] mem_rdata_i, mem_wdata_o;

    always #5 clk = ~clk;

    dcache_2way_wb #(.INDEX_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_rreq_i(cpu_rreq_i), .cpu_raddr_i(cpu_raddr_i),
        .cpu_wreq_i(cpu_wreq_i), .cpu_waddr_i(cpu_waddr_i),
        .cpu_wdata_i(cpu_wdata_i), .cpu_sel_i(cpu_sel_i),
        .cpu_rdata_o(cpu_rdata_o), .stallreq_o(stallreq_o),
        .mem_rreq_o(mem_rreq_o), .mem_raddr_o(mem_raddr_o),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .mem_wreq_o(mem_wreq_o), .mem_waddr_o(mem_waddr_o),
        .mem_wdata_o(mem_wdata_o), .mem_wack_i(mem_wack_i)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    // ---------------- memory image and CPU-visible golden data ----------------
    logic [31:0] mem_img [int unsigned];
    logic [31:0] gold    [int unsigned];

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return a * 32'h9E3779B1 + 32'h01234567;
    endfunction
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return mem_img.exists(a) ? mem_img[a] : init_word(a);
    endfunction
    function automatic logic [31:0] gold_word(input logic [31:0] a);
        return gold.exists(a) ? gold[a] : mem_word(a);
    endfunction
    function automatic logic [127:0] mem_line(input logic [31:0] la);
        logic [127:0] l;
        for (int k = 0; k < 4; k++) l[32*k +: 32] = mem_word(la + 32'(4*k));
        return l;
    endfunction
    function automatic logic [127:0] gold_line(input logic [31:0] la);
        logic [127:0] l;
        for (int k = 0; k < 4; k++) l[32*k +: 32] = gold_word(la + 32'(4*k));
        return l;
    endfunction
    task automatic gold_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] sel);
        logic [31:0] w;
        w = gold_word(a);
        for (int b = 0; b < 4; b++) if (sel[b]) w[8*b +: 8] = d[8*b +: 8];
        gold[a] = w;
    endtask

    // ---------------- transaction-level cache occupancy model ----------------
    logic [19:0] m_tag [256][2];
    bit          m_val [256][2];
    bit          m_dty [256][2];
    bit          m_lru [256];
    logic [31:0] exp_rd_q[$], exp_wr_q[$];
    logic [31:0] rd_log[$], wr_log[$];

    task automatic model_reset();
        for (int s = 0; s < 256; s++) begin
            m_lru[s] = 1'b0;
            for (int w = 0; w < 2; w++) begin m_val[s][w] = 1'b0; m_dty[s][w] = 1'b0; end
        end
    endtask

    // Returns 1 on a miss and queues the expected memory traffic.
    function automatic bit model_access(input logic [31:0] a, input bit wr);
        int          s = int'(a[11:4]);
        logic [19:0] t = a[31:12];
        int          v;
        for (int w = 0; w < 2; w++) begin
            if (m_val[s][w] && m_tag[s][w] == t) begin
                m_lru[s] = (w == 0);
                if (wr) m_dty[s][w] = 1'b1;
                return 1'b0;
            end
        end
        v = !m_val[s][0] ? 0 : (!m_val[s][1] ? 1 : int'(m_lru[s]));
        if (m_dty[s][v] && m_val[s][v]) exp_wr_q.push_back({m_tag[s][v], a[11:4], 4'h0});
        exp_rd_q.push_back({t, a[11:4], 4'h0});
        m_tag[s][v] = t;
        m_val[s][v] = 1'b1;
        m_dty[s][v] = wr;
        m_lru[s]    = (v == 0);
        return 1'b1;
    endfunction

    // ---------------- memory responder ----------------
    bit           mem_hold = 1'b0;
    bit           free_run = 1'b0;
    logic [31:0]  last_raddr = '1, last_waddr = '1;
    logic [127:0] last_wdata = '0;

    initial begin
        int cnt;
        cnt = -1;
        mem_rvalid_i = 1'b0; mem_wack_i = 1'b0; mem_rdata_i = '0;
        forever begin
            @(negedge clk);
            mem_rvalid_i = 1'b0;
            mem_wack_i   = 1'b0;
            if (!rst_n || !(mem_rreq_o || mem_wreq_o)) cnt = -1;
            else if (!mem_hold) begin
                if (cnt < 0) cnt = $urandom_range(0, 3);
                if (cnt == 0) begin
                    if (mem_rreq_o) begin
                        mem_rdata_i  = mem_line(mem_raddr_o);
                        mem_rvalid_i = 1'b1;
                        last_raddr   = mem_raddr_o;
                        rd_log.push_back(mem_raddr_o);
                    end else begin
                        chk("wb_data", mem_wdata_o, gold_line(mem_waddr_o));
                        for (int k = 0; k < 4; k++)
                            mem_img[mem_waddr_o + 32'(4*k)] = mem_wdata_o[32*k +: 32];
                        mem_wack_i = 1'b1;
                        last_waddr = mem_waddr_o;
                        last_wdata = mem_wdata_o;
                        wr_log.push_back(mem_waddr_o);
                    end
                    cnt = -1;
                end else cnt--;
            end
        end
    end

    // Per-cycle compare of the memory-side outputs against the model.
    always @(posedge clk) begin
        #2;
        chk("mem_req_excl", mem_rreq_o & mem_wreq_o, 1'b0);
        if (mem_rreq_o && !free_run) begin
            if (rd_log.size() < exp_rd_q.size())
                chk("refill_addr", mem_raddr_o, exp_rd_q[rd_log.size()]);
            else chk("unexpected_refill", mem_rreq_o, 1'b0);
        end
        if (mem_wreq_o && !free_run) begin
            if (wr_log.size() < exp_wr_q.size())
                chk("wb_addr", mem_waddr_o, exp_wr_q[wr_log.size()]);
            else chk("unexpected_wb", mem_wreq_o, 1'b0);
        end
    end

    // ---------------- CPU driver ----------------
    logic [31:0] last_rdata = '0;

    task automatic do_op(input bit rd, input bit wr, input logic [31:0] ra, input logic [31:0] wa,
                         input logic [31:0] wd, input logic [3:0] sel,
                         output int stalls, output logic [31:0] rdata);
        bit          miss;
        int          t, base;
        logic [31:0] exp_rd;
        miss = 1'b0;
        exp_rd_q.delete(); exp_wr_q.delete(); rd_log.delete(); wr_log.delete();
        if (wr) begin
            if (model_access(wa, 1'b1)) miss = 1'b1;
            gold_write(wa, wd, sel);
        end
        exp_rd = last_rdata;
        if (rd) begin
            if (model_access(ra, 1'b0)) miss = 1'b1;
            exp_rd = gold_word(ra);
        end
        @(negedge clk);
        cpu_rreq_i = rd; cpu_wreq_i = wr; cpu_raddr_i = ra; cpu_waddr_i = wa;
        cpu_wdata_i = wd; cpu_sel_i = sel;
        t = 0;
        while (stallreq_o && t < 100) begin @(negedge clk); t++; end
        chk("accept_timeout", stallreq_o, 1'b0);
        @(posedge clk); #1;
        cpu_rreq_i = 1'b0; cpu_wreq_i = 1'b0;
        stalls = 0;
        @(negedge clk);
        while (stallreq_o && stalls < 200) begin stalls++; @(negedge clk); end
        chk("op_timeout", stallreq_o, 1'b0);
        @(posedge clk); #1;
        rdata = cpu_rdata_o;
        chk(rd ? "read_data" : "rdata_held", rdata, exp_rd);
        last_rdata = exp_rd;
        base = (rd && wr) ? 1 : 0;
        if (!miss) chk("hit_stalls", stalls, base);
        else       chk("miss_stalls", stalls > base, 1'b1);
        chk("refill_count", rd_log.size(), exp_rd_q.size());
        chk("wb_count", wr_log.size(), exp_wr_q.size());
    endtask

    function automatic logic [31:0] rand_addr();
        logic [19:0] tags [4];
        tags = '{20'h00000, 20'h00001, 20'h00002, 20'hFFFFF};
        return {tags[$urandom_range(0, 3)], 8'($urandom_range(0, 2)), 2'($urandom_range(0, 3)), 2'b00};
    endfunction

    // ---------------- main sequence ----------------
    int          st;
    logic [31:0] rd;
    logic [31:0] t1d [4] = '{32'h10101010, 32'h20202020, 32'h30303030, 32'h40404040};
    logic [31:0] t2d [4] = '{32'h51515151, 32'h62626262, 32'h73737373, 32'h84848484};

    initial begin
        cpu_rreq_i = 1'b0; cpu_wreq_i = 1'b0; cpu_raddr_i = '0; cpu_waddr_i = '0;
        cpu_wdata_i = '0; cpu_sel_i = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_stall", stallreq_o, 1'b0);
        chk("rst_rreq", mem_rreq_o, 1'b0);
        chk("rst_wreq", mem_wreq_o, 1'b0);
        chk("rst_rdata", cpu_rdata_o, 32'h0);
        chk("rst_mem_addrs", {mem_raddr_o, mem_waddr_o}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // T1: write-allocate into set 0, way0
        do_op(1'b0, 1'b1, 32'h0, 32'h0, t1d[0], 4'hF, st, rd);
        chk("t1_refill_addr", last_raddr, 32'h0000_0000);
        for (int k = 1; k < 4; k++) begin
            do_op(1'b0, 1'b1, 32'h0, 32'(4*k), t1d[k], 4'hF, st, rd);
            chk("t1_hit_stalls", st, 0);
        end

        // T2: second line of set 0 goes to way1, then a read hit
        do_op(1'b0, 1'b1, 32'h0, 32'h1000, t2d[0], 4'hF, st, rd);
        chk("t2_refill_addr", last_raddr, 32'h0000_1000);
        for (int k = 1; k < 4; k++) do_op(1'b0, 1'b1, 32'h0, 32'h1000 + 32'(4*k), t2d[k], 4'hF, st, rd);
        do_op(1'b1, 1'b0, 32'h100C, 32'h0, 32'h0, 4'h0, st, rd);
        chk("t2_read_hit", rd, 32'h84848484);
        chk("t2_hit_latency", st, 0);

        // T3: set 0 full, way0 is LRU and dirty -> writeback then refill
        do_op(1'b1, 1'b0, 32'h2000, 32'h0, 32'h0, 4'h0, st, rd);
        chk("t3_wb_addr", last_waddr, 32'h0000_0000);
        chk("t3_wb_data", last_wdata, 128'h40404040_30303030_20202020_10101010);
        chk("t3_refill_addr", last_raddr, 32'h0000_2000);
        chk("t3_read_data", rd, init_word(32'h2000));

        // T4: partial byte write
        do_op(1'b0, 1'b1, 32'h0, 32'h2004, 32'h11223344, 4'hF, st, rd);
        do_op(1'b0, 1'b1, 32'h0, 32'h2004, 32'hAABBCCDD, 4'b0010, st, rd);
        do_op(1'b1, 1'b0, 32'h2004, 32'h0, 32'h0, 4'h0, st, rd);
        chk("t4_merge", rd, 32'h1122CC44);

        // T5: simultaneous write and read of the same word
        do_op(1'b1, 1'b1, 32'h1008, 32'h1008, 32'hDEADBEEF, 4'hF, st, rd);
        chk("t5_read_after_write", rd, 32'hDEADBEEF);
        chk("t5_stalls", st, 1);

        // Random traffic over a few conflicting sets
        for (int i = 0; i < 400; i++) begin
            int kind;
            kind = $urandom_range(0, 2);
            do_op(kind != 1, kind != 0, rand_addr(), rand_addr(), $urandom, 4'($urandom), st, rd);
        end

        // T6: reset while a refill is outstanding
        free_run = 1'b1;
        mem_hold = 1'b1;
        @(negedge clk);
        cpu_rreq_i = 1'b1; cpu_raddr_i = 32'h3050;
        @(posedge clk); #1;
        cpu_rreq_i = 1'b0;
        st = 0;
        while (!mem_rreq_o && st < 20) begin @(negedge clk); st++; end
        chk("t6_in_refill", mem_rreq_o, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rreq_drop", mem_rreq_o, 1'b0);
        chk("t6_stall_drop", stallreq_o, 1'b0);
        chk("t6_rdata_clear", cpu_rdata_o, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mem_hold = 1'b0;
        free_run = 1'b0;
        model_reset();
        gold.delete();
        last_rdata = '0;
        last_raddr = '1;
        do_op(1'b1, 1'b0, 32'h1000, 32'h0, 32'h0, 4'h0, st, rd);
        chk("t6_miss_after_reset", st > 0, 1'b1);
        chk("t6_refill_addr", last_raddr, 32'h0000_1000);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, actual running required finished");
        $fatal(1, "watchdog");
    end
endmodule
